link_freq_meter: RTL and testbench
==================================

// Module: link_freq_meter
// PURPOSE
//  Conditions the raw SWIPT link reference before it reaches the PLL/PFD.
//  - Synchronises and glitch-filters link_raw into a clean link.
//  - Measures the link period in clk cycles.
//  - Raises freq_rdy once the period is stable; the PLL frequency loop uses it to start tracking.
//  - Flags loss of link.
//  - Sits directly upstream of the PLL: drives its link and freq_rdy inputs.
// PARAMETERS
//  SYNC_STAGES  2     synchroniser flops on link_raw (>=2)
//  GLITCH       4     consecutive clk cycles a new level must persist before link follows
//  MIN_PERIOD   1000  shortest accepted period, clk cycles (100 kHz at 100 MHz clk)
//  MAX_PERIOD   5000  longest accepted period, clk cycles (20 kHz)
//  TOL          64    max |period - previous period| counted as a match, cycles
//  LOCK_CNT     8     consecutive matches required for freq_rdy
//  TIMEOUT      10000 cycles without a rising edge before lost asserts
// PORTS
//  clk         in   1   system clock, 100 MHz
//  rst         in   1   synchronous reset, active-high
//  swiptAlive  in   1   power link present; low forces IDLE
//  link_raw    in   1   asynchronous link reference from the receiver comparator
//  link        out  1   synchronised, glitch-filtered link (to PLL/PFD)
//  freq_rdy    out  1   period stable for LOCK_CNT matches
//  period      out  32  last captured period in clk cycles; holds between captures
//  period_vld  out  1   1-cycle pulse when period updates
//  lost        out  1   no rising edge for TIMEOUT cycles
// BEHAVIOUR
//  Reset: rst sampled on posedge clk, highest priority.
//   - Outputs: link=0, freq_rdy=0, period=0, period_vld=0, lost=0.
//   - Internal: state=IDLE, sync chain=0, counters=0.
//  Filter: glitch counter counts while sync output != link and clears when equal.
//   - At count GLITCH, link toggles and the counter clears.
//   - Latency link_raw -> link = SYNC_STAGES+GLITCH cycles.
//  Edge: rise = link & ~link_q, where link_q is link delayed 1 cycle. Detected in cycle T.
//  pcnt: 32-bit counter.
//   - Set to 1 on rise; otherwise +1 per cycle.
//   - Saturates at TIMEOUT.
//  FSM (next state registered; outputs update at T+1):
//   IDLE    -> ARM when swiptAlive=1. pcnt, match_cnt and prev_vld cleared.
//   ARM     -> MEAS on first rise. No capture.
//   MEAS    on rise:
//           - period<=pcnt, period_vld<=1.
//           - A capture is a match iff MIN_PERIOD<=pcnt<=MAX_PERIOD and prev_vld
//             and |pcnt-prev|<=TOL.
//           - On a match, match_cnt+1; otherwise match_cnt=0.
//           - Then prev<=pcnt, prev_vld<=1.
//           - match_cnt reaching LOCK_CNT -> LOCKED, with freq_rdy=1 from T+1.
//   LOCKED  captures as in MEAS.
//           - A non-match -> MEAS, freq_rdy=0 at T+1, match_cnt=0.
//   LOST    entered from MEAS/LOCKED/ARM when pcnt==TIMEOUT with no rise.
//           - lost=1, freq_rdy=0, match_cnt=0, prev_vld=0.
//           - -> MEAS on next rise, with lost=0 at T+1 and no capture on that edge.
//  swiptAlive=0 in any state: next cycle -> IDLE, freq_rdy=0, lost=0; period holds.
//  Rise in same cycle as pcnt==TIMEOUT: the rise wins (capture, no LOST).
//  Out-of-range periods still pulse period_vld and update period.
//  match_cnt width: clog2(LOCK_CNT+1). Period differences: 33-bit signed, no wrap.
// TESTING
//  1 rst, swiptAlive=1, link_raw square wave period 2439 (41 kHz)
//    -> period=2439 on each period_vld; freq_rdy=1 one cycle after the 10th rise.
//  2 link_raw pulses: 3-cycle pulse -> link unchanged; 4-cycle pulse -> link pulses,
//    delayed SYNC_STAGES+GLITCH=6 cycles.
//  3 Locked at 2439, one period of 2600
//    -> period_vld with period=2600, freq_rdy=0 next cycle; freq_rdy=1 after 8 further matched periods.
//  4 Locked, link_raw held low
//    -> lost=1 and freq_rdy=0 when pcnt reaches 10000; link resumes -> lost=0 after first rise.
//  5 Period 900 and period 6000 -> period_vld pulses with those values, freq_rdy never 1.
//  6 swiptAlive=0 while locked -> freq_rdy=0 next cycle, state IDLE;
//    rst mid-MEAS -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/link_freq_meter.sv
// Link reference conditioner: synchronises and glitch-filters link_raw, measures its
// period in clk cycles, qualifies frequency stability for the PLL and flags loss of link.
module link_freq_meter #(
   parameter int SYNC_STAGES = 2,
   parameter int GLITCH      = 4,
   parameter int MIN_PERIOD  = 1000,
   parameter int MAX_PERIOD  = 5000,
   parameter int TOL         = 64,
   parameter int LOCK_CNT    = 8,
   parameter int TIMEOUT     = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        swiptAlive,
   input  logic        link_raw,
   output logic        link,
   output logic        freq_rdy,
   output logic [31:0] period,
   output logic        period_vld,
   output logic        lost,
   output logic [2:0]  state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARM    = 3'd1;
   localparam logic [2:0] S_MEAS   = 3'd2;
   localparam logic [2:0] S_LOCKED = 3'd3;
   localparam logic [2:0] S_LOST   = 3'd4;

   localparam int GW = $clog2(GLITCH + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [GW-1:0]          gcnt;
   logic                   link_q;
   logic                   rise;
   logic [31:0]            pcnt;
   logic [31:0]            prev;
   logic                   prev_vld;
   logic [MW-1:0]          match_cnt;
   logic [MW-1:0]          match_next;
   logic signed [32:0]     diff;
   logic signed [32:0]     adiff;
   logic                   in_range;
   logic                   is_match;
   logic                   timeout;

   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], link_raw};
   end

   // link only follows the synchronised level once it has held for GLITCH cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         link <= 1'b0;
         gcnt <= '0;
      end else if (sync[SYNC_STAGES-1] != link) begin
         if (gcnt == GW'(GLITCH - 1)) begin
            link <= ~link;
            gcnt <= '0;
         end else begin
            gcnt <= gcnt + GW'(1);
         end
      end else begin
         gcnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) link_q <= 1'b0;
      else     link_q <= link;
   end

   assign rise = link & ~link_q;

   always_ff @(posedge clk) begin
      if (rst || state == S_IDLE) pcnt <= '0;
      else if (rise)              pcnt <= 32'd1;
      else if (pcnt < 32'(TIMEOUT)) pcnt <= pcnt + 32'd1;
   end

   assign diff       = $signed({1'b0, pcnt}) - $signed({1'b0, prev});
   assign adiff      = (diff < 0) ? -diff : diff;
   assign in_range   = (pcnt >= 32'(MIN_PERIOD)) && (pcnt <= 32'(MAX_PERIOD));
   assign is_match   = in_range && prev_vld && (adiff <= $signed(33'(TOL)));
   assign timeout    = (pcnt == 32'(TIMEOUT));
   // Saturate so a long locked run cannot wrap the counter back below LOCK_CNT
   assign match_next = (match_cnt == MW'(LOCK_CNT)) ? match_cnt : match_cnt + MW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         freq_rdy   <= 1'b0;
         period     <= '0;
         period_vld <= 1'b0;
         lost       <= 1'b0;
         prev       <= '0;
         prev_vld   <= 1'b0;
         match_cnt  <= '0;
      end else begin
         period_vld <= 1'b0;
         if (!swiptAlive) begin
            state     <= S_IDLE;
            freq_rdy  <= 1'b0;
            lost      <= 1'b0;
            match_cnt <= '0;
            prev_vld  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  state     <= S_ARM;
                  match_cnt <= '0;
                  prev_vld  <= 1'b0;
               end
               S_ARM: begin
                  if (rise) begin
                     state <= S_MEAS;
                  end else if (timeout) begin
                     state     <= S_LOST;
                     lost      <= 1'b1;
                     freq_rdy  <= 1'b0;
                     match_cnt <= '0;
                     prev_vld  <= 1'b0;
                  end
               end
               S_MEAS, S_LOCKED: begin
                  // a rise in the timeout cycle still counts as a capture
                  if (rise) begin
                     period     <= pcnt;
                     period_vld <= 1'b1;
                     prev       <= pcnt;
                     prev_vld   <= 1'b1;
                     if (is_match) begin
                        match_cnt <= match_next;
                        if (match_next >= MW'(LOCK_CNT)) begin
                           state    <= S_LOCKED;
                           freq_rdy <= 1'b1;
                        end
                     end else begin
                        match_cnt <= '0;
                        state     <= S_MEAS;
                        freq_rdy  <= 1'b0;
                     end
                  end else if (timeout) begin
                     state     <= S_LOST;
                     lost      <= 1'b1;
                     freq_rdy  <= 1'b0;
                     match_cnt <= '0;
                     prev_vld  <= 1'b0;
                  end
               end
               S_LOST: begin
                  if (rise) begin
                     state <= S_MEAS;
                     lost  <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_link_freq_meter.sv
// Bench for link_freq_meter: square-wave link_raw stimulus, a rise-level lock model
// feeding an expected-capture queue, plus glitch, loss, idle and reset checks.
module tb_link_freq_meter;

   localparam int TIMEOUT = 10000;
   localparam int MIN_P   = 1000;
   localparam int MAX_P   = 5000;
   localparam int TOL     = 64;
   localparam int LOCK    = 8;

   localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_LOCK = 3, M_LOST = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        swiptAlive;
   logic        link_raw;
   logic        link;
   logic        freq_rdy;
   logic [31:0] period;
   logic        period_vld;
   logic        lost;
   logic [2:0]  state;

   link_freq_meter dut (
      .clk        (clk),
      .rst        (rst),
      .swiptAlive (swiptAlive),
      .link_raw   (link_raw),
      .link       (link),
      .freq_rdy   (freq_rdy),
      .period     (period),
      .period_vld (period_vld),
      .lost       (lost),
      .state      (state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard
   logic [31:0] exp_q[$];
   logic        exp_rdy_q[$];

   int m_mode, m_prev, m_match, m_last_period;
   bit m_prev_vld, m_rdy;
   int drv_cyc, last_rise;

   task automatic model_idle();
      m_mode = M_IDLE; m_prev_vld = 0; m_match = 0; m_rdy = 0;
   endtask

   // Called at every driven link_raw rise with the gap since the previous one.
   task automatic model_rise(input int g);
      bit hit;
      int d;
      if ((m_mode == M_MEAS || m_mode == M_LOCK || m_mode == M_ARM) && g > TIMEOUT) begin
         m_mode = M_LOST; m_match = 0; m_prev_vld = 0; m_rdy = 0;
      end
      if (m_mode == M_ARM || m_mode == M_LOST) begin
         m_mode = M_MEAS;
      end else if (m_mode == M_MEAS || m_mode == M_LOCK) begin
         d   = (g > m_prev) ? g - m_prev : m_prev - g;
         hit = (g >= MIN_P) && (g <= MAX_P) && m_prev_vld && (d <= TOL);
         m_match = hit ? m_match + 1 : 0;
         m_prev = g; m_prev_vld = 1; m_last_period = g;
         if (m_match >= LOCK) begin m_mode = M_LOCK; m_rdy = 1; end
         else begin m_mode = M_MEAS; m_rdy = 0; end
         exp_q.push_back(32'(g));
         exp_rdy_q.push_back(m_rdy);
      end
   endtask

   // driver tasks
   task automatic wait_n(input int n);
      repeat (n) begin
         @(negedge clk);
         drv_cyc++;
      end
   endtask

   task automatic raw_rise();
      link_raw = 1'b1;
      model_rise(drv_cyc - last_rise);
      last_rise = drv_cyc;
   endtask

   task automatic gen_period(input int p);
      raw_rise();
      wait_n(p / 2);
      link_raw = 1'b0;
      wait_n(p - p / 2);
   endtask

   task automatic alive_up();
      swiptAlive = 1'b1;
      m_mode = M_ARM;
      last_rise = drv_cyc;
   endtask

   task automatic glitch_pulse(input int w, output int first_hi, output int width);
      first_hi = 0;
      width    = 0;
      link_raw = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         wait_n(1);
         if (link === 1'b1) begin
            if (first_hi == 0) first_hi = i;
            width++;
         end
         if (i == w) link_raw = 1'b0;
      end
   endtask

   // capture monitor and loss-delay monitor
   int  mon_cyc = 0, link_rise_at = 0;
   logic link_d = 1'b0, lost_d = 1'b0;
   bit  watch_rdy = 0, rdy_seen = 0;

   always @(negedge clk) begin
      mon_cyc++;
      if (rst !== 1'b1) begin
         if (period_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("vld_unexpected", 32'(period_vld), 32'd0);
            end else begin
               check("period", period, exp_q.pop_front());
               check("freq_rdy_at_capture", 32'(freq_rdy), 32'(exp_rdy_q.pop_front()));
            end
         end
         if (link === 1'b1 && link_d === 1'b0) link_rise_at = mon_cyc;
         if (lost === 1'b1 && lost_d === 1'b0)
            check("lost_delay", 32'(mon_cyc - link_rise_at), 32'(TIMEOUT + 1));
         if (watch_rdy && freq_rdy === 1'b1) rdy_seen = 1;
      end
      link_d = link;
      lost_d = lost;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fh, wd, w, base;
      bit got;
      drv_cyc = 0; last_rise = 0;
      model_idle();
      rst = 1'b1; swiptAlive = 1'b0; link_raw = 1'b0;
      wait_n(3);
      check("rst_link", 32'(link), 32'd0);
      check("rst_freq_rdy", 32'(freq_rdy), 32'd0);
      check("rst_period", period, 32'd0);
      check("rst_period_vld", 32'(period_vld), 32'd0);
      check("rst_lost", 32'(lost), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      rst = 1'b0;
      wait_n(2);

      // glitch filter, exercised while idle
      glitch_pulse(3, fh, wd);
      check("glitch3_first", 32'(fh), 32'd0);
      check("glitch3_width", 32'(wd), 32'd0);
      glitch_pulse(4, fh, wd);
      check("glitch4_latency", 32'(fh), 32'd6);
      check("glitch4_width", 32'(wd), 32'd4);
      w = $urandom_range(1, 3);
      glitch_pulse(w, fh, wd);
      check("glitch_short_width", 32'(wd), 32'd0);
      w = $urandom_range(5, 8);
      glitch_pulse(w, fh, wd);
      check("glitch_long_latency", 32'(fh), 32'd6);
      check("glitch_long_width", 32'(wd), 32'(w));

      // steady 2439-cycle reference, lock on the 10th rise
      alive_up();
      wait_n(5);
      for (int i = 0; i < 10; i++) gen_period(2439);

      // one long period unlocks, then relock
      gen_period(2600);
      for (int i = 0; i < 10; i++) gen_period(2439);
      check("locked_before_hold", 32'(freq_rdy), 32'(m_rdy));

      // hold low until loss is flagged
      got = 0;
      for (int i = 0; i < 12000 && !got; i++) begin
         wait_n(1);
         if (lost === 1'b1) got = 1;
      end
      check("lost_asserted", 32'(got), 32'd1);
      check("lost_freq_rdy", 32'(freq_rdy), 32'd0);

      // out-of-range periods after the link resumes
      watch_rdy = 1;
      gen_period(900);
      check("lost_cleared", 32'(lost), 32'd0);
      gen_period(6000);
      gen_period(1000);
      // tolerance boundary: +64 matches, +65 does not
      gen_period(1064);
      watch_rdy = 0;
      check("out_of_range_no_rdy", 32'(rdy_seen), 32'd0);
      gen_period(1129);

      // random jitter around the last period
      base = 1129;
      for (int i = 0; i < 10; i++) gen_period(base + $urandom_range(0, 60) - 30);
      check("random_locked", 32'(freq_rdy), 32'(m_rdy));
      check("random_locked_expect", 32'(freq_rdy), 32'd1);

      // power link drops while locked
      swiptAlive = 1'b0;
      model_idle();
      wait_n(1);
      check("drop_freq_rdy", 32'(freq_rdy), 32'd0);
      check("drop_state_idle", 32'(state), 32'd0);
      check("drop_lost", 32'(lost), 32'd0);
      check("drop_period_hold", period, 32'(m_last_period));
      wait_n(3);

      // re-arm, measure, then reset mid-measurement
      alive_up();
      wait_n(4);
      for (int i = 0; i < 3; i++) gen_period(1500);
      raw_rise();
      wait_n(20);
      check("pre_rst_link", 32'(link), 32'd1);
      rst = 1'b1;
      wait_n(1);
      model_idle();
      check("mid_rst_link", 32'(link), 32'd0);
      check("mid_rst_freq_rdy", 32'(freq_rdy), 32'd0);
      check("mid_rst_period", period, 32'd0);
      check("mid_rst_period_vld", 32'(period_vld), 32'd0);
      check("mid_rst_lost", 32'(lost), 32'd0);
      check("mid_rst_state", 32'(state), 32'd0);
      rst = 1'b0; link_raw = 1'b0; swiptAlive = 1'b0;
      wait_n(20);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
